// File: rtl/seq_decoder_pkg.sv
// Shared encodings for the seq_decoder block: FSM state and mode constants.
package seq_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/seq_decoder_dwell_cnt.sv
// Dwell counter for scan mode: counts enabled cycles and pulses step on the
// last cycle of each dwell period, then restarts from zero.
module seq_decoder_dwell_cnt #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic step
);

    localparam int               CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt;

    // step is combinational so the index advances on the same edge the count clears
    assign step = en && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/seq_decoder.sv
// Registered N-to-M one-hot decoder with direct (strobed select) and scan modes.
// Optional macro SEQ_DECODER_DIR_EN adds a dir input so scan can count down.
module seq_decoder
    import seq_decoder_pkg::*;
#(
    parameter int SEL_W   = 3,
    parameter int NUM_OUT = 8,
    parameter int DWELL   = 4
) (
    input  logic               clk,
    input  logic               rst,
`ifdef SEQ_DECODER_DIR_EN
    input  logic               dir,
`endif
    input  logic               en,
    input  logic               mode,
    input  logic               sel_valid,
    input  logic [SEL_W-1:0]   sel,
    output logic [NUM_OUT-1:0] o,
    output logic [SEL_W-1:0]   idx,
    output logic               o_valid,
    output logic               err,
    output logic               wrap,
    output state_t             dbg_state
);

    localparam logic [SEL_W-1:0]   LAST_IDX  = SEL_W'(NUM_OUT - 1);
    localparam logic [SEL_W:0]     NUM_OUT_X = (SEL_W + 1)'(NUM_OUT);
    localparam logic [NUM_OUT-1:0] ONE       = NUM_OUT'(1);

    state_t           state;
    logic             scan_run;
    logic             scan_entry;
    logic             step;
    logic             sel_oor;
    logic [SEL_W-1:0] nxt_idx;
    logic             scan_wrap;

    assign dbg_state  = state;
    assign scan_run   = en && (mode == MODE_SCAN) && (state == ST_SCAN);
    assign scan_entry = en && (mode == MODE_SCAN) && (state != ST_SCAN);
    assign sel_oor    = {1'b0, sel} >= NUM_OUT_X;

    seq_decoder_dwell_cnt #(
        .DWELL(DWELL)
    ) u_dwell (
        .clk (clk),
        .rst (rst),
        .en  (scan_run),
        .clr (scan_entry),
        .step(step)
    );

    // Next scan index; wraps at both ends so idx never leaves 0..NUM_OUT-1
    always_comb begin
        nxt_idx   = idx + SEL_W'(1);
        scan_wrap = 1'b0;
`ifdef SEQ_DECODER_DIR_EN
        if (dir) begin
            if (idx == '0) begin
                nxt_idx   = LAST_IDX;
                scan_wrap = 1'b1;
            end else begin
                nxt_idx = idx - SEL_W'(1);
            end
        end else
`endif
        if (idx == LAST_IDX) begin
            nxt_idx   = '0;
            scan_wrap = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            o       <= '0;
            idx     <= '0;
            o_valid <= 1'b0;
            err     <= 1'b0;
            wrap    <= 1'b0;
        end else if (!en) begin
            err  <= 1'b0;
            wrap <= 1'b0;
        end else begin
            err  <= 1'b0;
            wrap <= 1'b0;
            if (mode == MODE_SCAN) begin
                if (state != ST_SCAN) begin
                    state   <= ST_SCAN;
                    idx     <= '0;
                    o       <= ONE;
                    o_valid <= 1'b1;
                end else if (step) begin
                    idx  <= nxt_idx;
                    o    <= ONE << nxt_idx;
                    wrap <= scan_wrap;
                end
            end else if (sel_valid) begin
                // A strobe coinciding with leaving SCAN is honoured immediately
                state <= ST_DIRECT;
                if (sel_oor) begin
                    o       <= '0;
                    o_valid <= 1'b0;
                    err     <= 1'b1;
                end else begin
                    o       <= ONE << sel;
                    idx     <= sel;
                    o_valid <= 1'b1;
                end
            end else if (state == ST_SCAN) begin
                state <= ST_DIRECT;
            end
        end
    end

endmodule
